// File: rtl/reg_file_wb.sv
// Purpose : architectural register file at the write-back end of the forwarding path.
// Latency : reads are combinational (zero latency); writes commit on the rising edge.
// Backpressure: none is taken; busy is asserted during the post-reset clear sweep
//               so the pipeline stalls until every register holds zero.
//
// Ports:
//   clk, rst                    clock and synchronous active-high reset
//   i_RegFile_we/wa/wd          write port driven by the WB stage
//   i_RegFile_ra1/ra2           read addresses from ID operand fetch
//   o_RegFile_rd1/rd2           combinational read data
//   o_RegFile_busy              high while the clear sweep is running
//
// Build option: define REGFILE_BYPASS_EN for same-cycle write-through to the
// read ports while running. Without it a same-cycle read sees the old value.
module reg_file_wb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_RegFile_we,
    input  logic [ADDR_W-1:0] i_RegFile_wa,
    input  logic [DATA_W-1:0] i_RegFile_wd,
    input  logic [ADDR_W-1:0] i_RegFile_ra1,
    input  logic [ADDR_W-1:0] i_RegFile_ra2,
    output logic [DATA_W-1:0] o_RegFile_rd1,
    output logic [DATA_W-1:0] o_RegFile_rd2,
    output logic              o_RegFile_busy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(1);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] clearCnt;
    logic              busyQ;

    // Register 0 is hardwired to zero, so storage starts at index 1.
    logic [DATA_W-1:0] regs [1:DEPTH-1];

    logic runWrite;
    assign runWrite = (state == RUN) && i_RegFile_we && (i_RegFile_wa != '0);

    // Single sequential block: FSM, sweep counter, registered busy and the array.
    // The array itself is not reset; the sweep is what zeroes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLEAR;
            clearCnt <= FIRST_ADDR;
            busyQ    <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    // clearCnt never wraps to 0 inside the sweep, but guard the
                    // index anyway so reg 0 can never be addressed.
                    if (clearCnt != '0) begin
                        regs[clearCnt] <= '0;
                    end
                    clearCnt <= clearCnt + FIRST_ADDR;
                    if (clearCnt == LAST_ADDR) begin
                        state <= RUN;
                        busyQ <= 1'b0;
                    end
                end
                RUN: begin
                    if (runWrite) begin
                        regs[i_RegFile_wa] <= i_RegFile_wd;
                    end
                end
                default: begin
                    state    <= CLEAR;
                    clearCnt <= FIRST_ADDR;
                    busyQ    <= 1'b1;
                end
            endcase
        end
    end

    assign o_RegFile_busy = busyQ;

    // Read ports. Address 0 always returns zero; otherwise the stored value,
    // optionally overridden by the in-flight write when bypass is built in.
    always_comb begin
        o_RegFile_rd1 = '0;
        o_RegFile_rd2 = '0;
        if (i_RegFile_ra1 != '0) begin
            o_RegFile_rd1 = regs[i_RegFile_ra1];
`ifdef REGFILE_BYPASS_EN
            if (runWrite && (i_RegFile_wa == i_RegFile_ra1)) begin
                o_RegFile_rd1 = i_RegFile_wd;
            end
`endif
        end
        if (i_RegFile_ra2 != '0) begin
            o_RegFile_rd2 = regs[i_RegFile_ra2];
`ifdef REGFILE_BYPASS_EN
            if (runWrite && (i_RegFile_wa == i_RegFile_ra2)) begin
                o_RegFile_rd2 = i_RegFile_wd;
            end
`endif
        end
    end

endmodule
